prbs16_checker: RTL and testbench



---
 rtl/prbs_pkg.sv | 23 ++
 rtl/sat_counter.sv | 23 ++
 rtl/prbs16_checker.sv | 154 +++++++++++++++
 tb/tb_prbs16_checker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Purpose: shared PRBS16 definitions for the pattern generator and checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package prbs_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;
  localparam logic [LFSR_W-1:0] GEN_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    FILL,
    HUNT,
    LOCK
  } chk_state_t;

  // Next feedback bit of the Fibonacci LFSR, which is also the transmitted bit.
  function automatic logic prbs_fb(input logic [LFSR_W-1:0] s);
    return ^(s & TAP_MASK);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: saturating up-counter with a synchronous clear (clear beats increment).
// Latency: 1 cycle from inc/clr to cnt.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones, and zero on rst or clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/prbs16_checker.sv
// Purpose: self-synchronising PRBS16 bit-error checker (FILL -> HUNT -> LOCK) with loss-of-sync detection.
// Latency: 1 cycle from a valid input bit to locked/err_pulse/sync_loss/err_cnt.
// Backpressure: none; always accepts a bit when in_valid is high, and holds state otherwise.
// Optional: define PRBS_CHK_BITCNT_EN to add the bit_cnt output (valid bits received in LOCK).
module prbs16_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = 32,
  parameter int LOSS_WINDOW  = 64,
  parameter int LOSS_ERRS    = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sync_loss
`ifdef PRBS_CHK_BITCNT_EN
  , output logic [31:0]    bit_cnt
`endif
);

  localparam logic [7:0] LOCK_M   = 8'(LOCK_MATCHES);
  localparam logic [8:0] WIN_LAST = 9'(LOSS_WINDOW - 1);
  localparam logic [8:0] ERR_LIM  = 9'(LOSS_ERRS);

  chk_state_t        state, state_n;
  logic [LFSR_W-1:0] s, s_n;
  logic [3:0]        fill_cnt, fill_n;
  logic [7:0]        match_cnt, match_n;
  logic [8:0]        win_cnt, win_n;
  logic [8:0]        win_err, werr_n, werr_sum;
  logic              p;
  logic              err_hit;
  logic              locked_n, sync_loss_n;

  // Next-state logic: advance only on valid bits; pulses default low every cycle.
  always_comb begin
    state_n     = state;
    s_n         = s;
    fill_n      = fill_cnt;
    match_n     = match_cnt;
    win_n       = win_cnt;
    werr_n      = win_err;
    werr_sum    = win_err;
    err_hit     = 1'b0;
    sync_loss_n = 1'b0;
    p           = prbs_fb(s);
    if (in_valid) begin
      case (state)
        FILL: begin
          s_n = {s[LFSR_W-2:0], in_bit};
          if (fill_cnt == 4'd15) begin
            state_n = HUNT;
            fill_n  = 4'd0;
          end else begin
            fill_n = fill_cnt + 4'd1;
          end
        end
        HUNT: begin
          s_n = {s[LFSR_W-2:0], in_bit};
          // An all-zero register predicts zeros forever, so it never counts as a match.
          if ((in_bit == p) && (s != '0)) begin
            if (match_cnt + 8'd1 == LOCK_M) begin
              state_n = LOCK;
              match_n = 8'd0;
              win_n   = 9'd0;
              werr_n  = 9'd0;
            end else begin
              match_n = match_cnt + 8'd1;
            end
          end else begin
            match_n = 8'd0;
          end
        end
        LOCK: begin
          // Free-run on the prediction so one corrupted bit yields exactly one error.
          s_n      = {s[LFSR_W-2:0], p};
          err_hit  = (in_bit != p);
          werr_sum = win_err + {8'd0, err_hit};
          if (werr_sum == ERR_LIM) begin
            state_n     = FILL;
            sync_loss_n = 1'b1;
            fill_n      = 4'd0;
            match_n     = 8'd0;
            win_n       = 9'd0;
            werr_n      = 9'd0;
          end else if (win_cnt == WIN_LAST) begin
            win_n  = 9'd0;
            werr_n = 9'd0;
          end else begin
            win_n  = win_cnt + 9'd1;
            werr_n = werr_sum;
          end
        end
        default: state_n = FILL;
      endcase
    end
    locked_n = (state_n == LOCK);
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      s         <= '0;
      fill_cnt  <= 4'd0;
      match_cnt <= 8'd0;
      win_cnt   <= 9'd0;
      win_err   <= 9'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      win_cnt   <= win_n;
      win_err   <= werr_n;
      locked    <= locked_n;
      err_pulse <= err_hit;
      sync_loss <= sync_loss_n;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_hit),
    .clr (clr_cnt),
    .cnt (err_cnt)
  );

`ifdef PRBS_CHK_BITCNT_EN
  logic bit_inc;
  assign bit_inc = in_valid && (state == LOCK);

  sat_counter #(.W(32)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bit_inc),
    .clr (clr_cnt),
    .cnt (bit_cnt)
  );
`else
  // Bit counter not built: no bit_cnt port and no extra state.
`endif

endmodule

// File: tb/tb_prbs16_checker.sv
// Purpose: directed scoreboard bench for prbs16_checker (default and CNT_W=4 instances in parallel).
// Latency: expectations are queued when a bit is driven and compared one cycle later.
// Backpressure: n/a.
module tb_prbs16_checker;
  import prbs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse, sync_loss;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4, sync_loss4;
  logic [3:0]  err_cnt4;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_cnt, bit_cnt4;
`endif

  always #5 clk = ~clk;

  prbs16_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .sync_loss(sync_loss)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_cnt(bit_cnt)
`endif
  );

  prbs16_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .sync_loss(sync_loss4)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_cnt(bit_cnt4)
`endif
  );

  typedef struct {
    logic        lk;
    logic        ep;
    logic        sl;
    logic [15:0] ec;
    logic [3:0]  ec4;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] gen = GEN_SEED;

  // Behavioural expectation: lock 48 clean valid bits after (re)start, then window-based loss.
  bit m_locked = 1'b0;
  int m_acq = 0;
  int m_win = 0;
  int m_werr = 0;
  int m_err = 0;
  int m_losses = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_pending();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("locked", {15'd0, locked}, {15'd0, e.lk});
      chk("err_pulse", {15'd0, err_pulse}, {15'd0, e.ep});
      chk("sync_loss", {15'd0, sync_loss}, {15'd0, e.sl});
      chk("err_cnt", err_cnt, e.ec);
      chk("err_cnt4", {12'd0, err_cnt4}, {12'd0, e.ec4});
    end
  endtask

  // One clock of stimulus: compare the previous result, drive new inputs, queue the expectation.
  task automatic step(input bit v, input bit flip, input bit zero, input bit clr, input bit rs);
    exp_t e;
    logic fb;
    @(negedge clk);
    check_pending();
    rst      = rs;
    clr_cnt  = clr;
    in_valid = v;
    if (v) begin
      fb  = prbs_fb(gen);
      gen = {gen[14:0], fb};
      in_bit = zero ? 1'b0 : (fb ^ flip);
    end else begin
      in_bit = 1'($urandom_range(0, 1));
    end
    e.ep = 1'b0;
    e.sl = 1'b0;
    if (rs) begin
      m_locked = 1'b0;
      m_acq = 0;
      m_win = 0;
      m_werr = 0;
      m_err = 0;
    end else begin
      if (v) begin
        if (!m_locked) begin
          if (zero) m_acq = 0;
          else begin
            m_acq++;
            if (m_acq == 48) begin
              m_locked = 1'b1;
              m_win = 0;
              m_werr = 0;
            end
          end
        end else begin
          if (flip) begin
            e.ep = 1'b1;
            m_err++;
            m_werr++;
          end
          if (m_werr == 4) begin
            e.sl = 1'b1;
            m_locked = 1'b0;
            m_losses++;
            m_acq = 0;
            m_win = 0;
            m_werr = 0;
          end else if (m_win == 63) begin
            m_win = 0;
            m_werr = 0;
          end else begin
            m_win++;
          end
        end
      end
      if (clr) m_err = 0;
    end
    e.lk  = m_locked;
    e.ec  = (m_err > 65535) ? 16'hFFFF : 16'(m_err);
    e.ec4 = (m_err > 15) ? 4'hF : 4'(m_err);
    exp_q.push_back(e);
  endtask

  initial begin
    int l0;
    bit f;

    // Reset state, then clean lock and a long error-free run.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10000; i++) step(1, 0, 0, 0, 0);

    // Three errors per window must never drop lock.
    for (int i = 0; i < 256; i++) begin
      f = m_locked && (m_win == 10 || m_win == 30 || m_win == 50);
      step(1, f, 0, 0, 0);
    end

    // Four errors in a window force resync; second time the 4th lands on the wrap bit.
    l0 = m_losses;
    for (int i = 0; i < 300; i++) begin
      f = m_locked && (((m_losses == l0) && (m_win >= 5) && (m_win <= 8)) ||
                       ((m_losses == l0 + 1) && (m_win >= 60)));
      step(1, f, 0, 0, 0);
    end

    // Clear in the same cycle as an error wins.
    step(1, m_locked, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);

    // Twenty spaced errors: the 4-bit counter sticks at F.
    for (int i = 0; i < 500; i++) step(1, m_locked && (i % 25 == 0), 0, 0, 0);

    // Reset mid-LOCK, relock, then a single error on the 200th bit.
    step(1, 0, 0, 0, 1);
    for (int i = 1; i <= 300; i++) step(1, (i == 200), 0, 0, 0);

    // Gapped valid at 50% duty.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 0, 0, 0, 0);

    // All-zero input never locks and never accumulates matches.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 1, 0, 0);
      @(posedge clk);
      #1;
      chk("match_cnt", {8'd0, dut.match_cnt}, 16'd0);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    @(negedge clk);
    check_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
